spi_boot_loader: RTL

SPI_BOOT_LOADER -- requirements
Module: spi_boot_loader

---
 rtl/spi_boot_loader.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/spi_boot_loader.sv
// spi_boot_loader
//   Copies a 2**BITDEPTH byte image out of a SPI NOR flash (mode 0, READ 03h)
//   into a RAM through a NORA slave write port, then pulses done_o.
//
// Ports
//   clk, reset          : single clock, synchronous active-high reset
//   start_i             : one-cycle pulse, starts a load (honoured in IDLE only)
//   busy_o / done_o     : load in progress / one-cycle completion pulse
//   spi_csn_o, spi_sck_o, spi_mosi_o, spi_miso_i : SPI flash master, mode 0
//   slv_addr_o, slv_datawr_o, slv_datawr_valid_o, slv_req_o, slv_rwn_o :
//                         RAM write port (rwn: 1=read, 0=write)
//   dbg_state_o         : current FSM state, for observation only
//
// Handshake: the RAM write is a fire-and-forget strobe. slv_req_o and
// slv_datawr_valid_o are high together for exactly one clk (the WRITE state)
// with address and data stable in that cycle; the RAM has no way to stall it.
module spi_boot_loader #(
  parameter int          BITDEPTH   = 9,
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter int          CLKDIV     = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                spi_csn_o,
  output logic                spi_sck_o,
  output logic                spi_mosi_o,
  input  logic                spi_miso_i,
  output logic [BITDEPTH-1:0] slv_addr_o,
  output logic [7:0]          slv_datawr_o,
  output logic                slv_datawr_valid_o,
  output logic                slv_req_o,
  output logic                slv_rwn_o,
  output logic [2:0]          dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    DATA   = 3'd2,
    WRITE  = 3'd3,
    FINISH = 3'd4
  } state_t;

  // One counter serves both the SCK half-period and the FINISH hold time.
  localparam int                CW         = $clog2(2 * CLKDIV) + 1;
  localparam logic [CW-1:0]     PHASE_LAST = CW'(CLKDIV - 1);
  localparam logic [CW-1:0]     FIN_LAST   = CW'(2 * CLKDIV - 1);
  localparam logic [CW-1:0]     CNT_ONE    = CW'(1);
  localparam logic [BITDEPTH:0] IDX_LAST   = (BITDEPTH + 1)'(2 ** BITDEPTH - 1);
  localparam logic [BITDEPTH:0] IDX_ONE    = (BITDEPTH + 1)'(1);

  state_t              state_q, state_d;
  logic [CW-1:0]       div_cnt;
  logic                sck_q;      // 0: low half of the bit, 1: high half
  logic [4:0]          bit_cnt;
  logic [31:0]         cmd_sr;
  logic [7:0]          rx_sr;
  logic [BITDEPTH:0]   idx;        // one spare bit so the last increment cannot alias 0
  logic                done_q;

  logic phase_end, bit_end, sample;

  assign phase_end = (div_cnt == PHASE_LAST);
  assign bit_end   = phase_end && sck_q;   // high half ends: sck falls, next bit starts
  assign sample    = phase_end && !sck_q;  // low half ends: sck rises on this edge

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_d            = state_q;
    spi_csn_o          = 1'b1;
    spi_sck_o          = 1'b0;
    spi_mosi_o         = 1'b0;
    busy_o             = 1'b1;
    slv_req_o          = 1'b0;
    slv_datawr_valid_o = 1'b0;
    slv_rwn_o          = 1'b1;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_d = CMD;
      end
      CMD: begin
        spi_csn_o  = 1'b0;
        spi_sck_o  = sck_q;
        spi_mosi_o = cmd_sr[31];
        if (bit_end && bit_cnt == 5'd31) state_d = DATA;
      end
      DATA: begin
        spi_csn_o = 1'b0;
        spi_sck_o = sck_q;
        if (bit_end && bit_cnt == 5'd7) state_d = WRITE;
      end
      WRITE: begin
        spi_csn_o          = 1'b0;
        slv_req_o          = 1'b1;
        slv_datawr_valid_o = 1'b1;
        slv_rwn_o          = 1'b0;
        state_d            = (idx == IDX_LAST) ? FINISH : DATA;
      end
      FINISH: begin
        if (div_cnt == FIN_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: SCK divider, shift registers, byte index, done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      sck_q   <= 1'b0;
      bit_cnt <= '0;
      cmd_sr  <= '0;
      rx_sr   <= '0;
      idx     <= '0;
      done_q  <= 1'b0;
    end else begin
      // done_o lands in the first IDLE cycle, the same cycle busy_o falls.
      done_q <= (state_q == FINISH) && (div_cnt == FIN_LAST);
      case (state_q)
        IDLE: begin
          div_cnt <= '0;
          sck_q   <= 1'b0;
          bit_cnt <= '0;
          if (start_i) begin
            cmd_sr <= {8'h03, FLASH_BASE};
            idx    <= '0;
          end
        end
        CMD, DATA: begin
          if (phase_end) begin
            div_cnt <= '0;
            sck_q   <= ~sck_q;
          end else begin
            div_cnt <= div_cnt + CNT_ONE;
          end
          if (sample && state_q == DATA) rx_sr <= {rx_sr[6:0], spi_miso_i};
          if (bit_end) begin
            // mosi moves only here, i.e. at the start of a low half
            cmd_sr  <= {cmd_sr[30:0], 1'b0};
            // the 5-bit counter wraps 31->0 on its own when CMD hands over
            bit_cnt <= (state_q == DATA && bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
          end
        end
        WRITE: begin
          idx     <= idx + IDX_ONE;
          div_cnt <= '0;
          sck_q   <= 1'b0;
        end
        FINISH: div_cnt <= div_cnt + CNT_ONE;
        default: ;
      endcase
    end
  end

  assign done_o       = done_q;
  assign slv_addr_o   = idx[BITDEPTH-1:0];
  assign slv_datawr_o = rx_sr;
  assign dbg_state_o  = state_q;

endmodule
